psx_ddr_arbiter: RTL and testbench
==================================

PSX_DDR_ARBITER -- requirements
Module: psx_ddr_arbiter

Interface
REQ-001 SHALL have parameter OWNER_DEPTH, default 4: max outstanding reads tracked (power of 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive lost arbitrations before forced grant to requester 1.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_rN_command (N=0,1)  in  1  requester N request.
REQ-006 i_rN_write  in  1  1=write, 0=read.
REQ-007 i_rN_commandSize  in  2  0=8 B, 1=32 B.
REQ-008 i_rN_adr  in  15  32-byte block address.
REQ-009 i_rN_subadr  in  3  sub-block within 32 B.
REQ-010 i_rN_writeMask  in  16  write mask.
REQ-011 i_rN_dataOut  in  256  write data.
REQ-012 o_rN_busy  out  1  0 = request captured this cycle.
REQ-013 o_rN_dataInValid  out  1  read data for requester N valid.
REQ-014 o_dataIn  out  256  read data, shared by both requesters.
REQ-015 o_command, o_write, o_commandSize[2], o_adr[15], o_subadr[3], o_writeMask[16], o_dataOut[256]  out  to memory client port.
REQ-016 i_busy  in  1; i_dataInValid  in  1; i_dataIn  in  256  from memory client port.
REQ-017 o_error  out  1  sticky: read data returned with no owner.

Function
REQ-018 Requester 0 = display fetch (high priority), requester 1 = GPU draw.
REQ-019 States IDLE, ISSUE; IDLE->ISSUE on capture; ISSUE->IDLE on cycle where o_command=1 and i_busy=0.
REQ-020 Eligible = i_rN_command=1 and (write, or owner FIFO not full).
REQ-021 In IDLE, winner = eligible requester 0, else eligible requester 1; winner's request fields registered, winner's o_rN_busy=0 that cycle.
REQ-022 o_rN_busy=1 in ISSUE, and in IDLE for any requester not winning.
REQ-023 Latency: capture cycle N -> o_command=1 from N+1, fields held stable until accepted; minimum 2 cycles per command.
REQ-024 On read acceptance, owner ID pushed into FIFO; on i_dataInValid, FIFO popped, o_rX_dataInValid=1 same cycle for popped owner; o_dataIn = i_dataIn combinationally.
REQ-025 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-026 FIFO pointers wrap modulo OWNER_DEPTH; full = OWNER_DEPTH entries.
REQ-027 i_dataInValid with FIFO empty: no valid output, o_error set until reset.
REQ-028 Writes produce no read-data return and no FIFO push.

Reset
REQ-029 On i_rst: state IDLE, FIFO empty, starve counter 0, o_command=0, all o_rN_busy=1, o_rN_dataInValid=0, o_error=0; registered fields 0.
REQ-030 Reset mid-ISSUE or with reads outstanding discards them; memory client SHALL be reset jointly.

Configuration
REQ-031 Macro PSX_DDR_ARB_STARVE_EN: defined -> counter increments when requester 1 eligible and loses, clears when it wins; at STARVE_LIMIT requester 1 wins next IDLE arbitration; undefined -> strict priority, no counter.

Structure
REQ-032 Package psx_ddr_arb_pkg: state enum, requester ID type, ADR/SUBADR/MASK/DATA width constants.
REQ-033 Sub-module psx_ddr_arb_owner_fifo: OWNER_DEPTH x 1-bit FIFO with full/empty.

Verification
REQ-034 Both request read 32 B same cycle -> r0 captured (o_r0_busy=0), r1 captured 2 cycles later; returns route to r0 then r1.
REQ-035 i_busy held 5 cycles in ISSUE -> o_command and o_adr stable 5 cycles, accepted cycle 6.
REQ-036 5 reads accepted, no returns, OWNER_DEPTH=4 -> 5th read held busy; writes still captured.
REQ-037 i_dataInValid with FIFO empty -> no o_rN_dataInValid, o_error=1 until i_rst.
REQ-038 With PSX_DDR_ARB_STARVE_EN, r0 and r1 requesting continuously -> r1 granted after 8 r0 grants; without macro -> r1 never granted.

Source files
------------

// File: rtl/psx_ddr_arb_pkg.sv
// Shared types and widths for the PSX DDR arbiter (display fetch vs GPU draw).
package psx_ddr_arb_pkg;

  localparam int ADR_W    = 15;
  localparam int SUBADR_W = 3;
  localparam int MASK_W   = 16;
  localparam int DATA_W   = 256;
  localparam int SIZE_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_DISPLAY = 1'b0;
  localparam req_id_t REQ_GPU     = 1'b1;

  typedef struct packed {
    logic                write;
    logic [SIZE_W-1:0]   size;
    logic [ADR_W-1:0]    adr;
    logic [SUBADR_W-1:0] subadr;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
  } mem_req_t;

endpackage

// File: rtl/psx_ddr_arb_owner_fifo.sv
// Read-owner FIFO: remembers which requester issued each outstanding read so
// returned data can be steered back in order.
module psx_ddr_arb_owner_fifo
  import psx_ddr_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t head_id,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] ids;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = ids[rd_ptr];
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psx_ddr_arbiter.sv
// Two-requester DDR client arbiter: display fetch (r0) has priority over GPU draw (r1).
// Build option PSX_DDR_ARB_STARVE_EN adds a starvation counter that forces a grant to r1.
module psx_ddr_arbiter
  import psx_ddr_arb_pkg::*;
#(
  parameter int OWNER_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                i_rst,

  input  logic                i_r0_command,
  input  logic                i_r0_write,
  input  logic [SIZE_W-1:0]   i_r0_commandSize,
  input  logic [ADR_W-1:0]    i_r0_adr,
  input  logic [SUBADR_W-1:0] i_r0_subadr,
  input  logic [MASK_W-1:0]   i_r0_writeMask,
  input  logic [DATA_W-1:0]   i_r0_dataOut,
  output logic                o_r0_busy,
  output logic                o_r0_dataInValid,

  input  logic                i_r1_command,
  input  logic                i_r1_write,
  input  logic [SIZE_W-1:0]   i_r1_commandSize,
  input  logic [ADR_W-1:0]    i_r1_adr,
  input  logic [SUBADR_W-1:0] i_r1_subadr,
  input  logic [MASK_W-1:0]   i_r1_writeMask,
  input  logic [DATA_W-1:0]   i_r1_dataOut,
  output logic                o_r1_busy,
  output logic                o_r1_dataInValid,

  output logic [DATA_W-1:0]   o_dataIn,

  output logic                o_command,
  output logic                o_write,
  output logic [SIZE_W-1:0]   o_commandSize,
  output logic [ADR_W-1:0]    o_adr,
  output logic [SUBADR_W-1:0] o_subadr,
  output logic [MASK_W-1:0]   o_writeMask,
  output logic [DATA_W-1:0]   o_dataOut,
  input  logic                i_busy,
  input  logic                i_dataInValid,
  input  logic [DATA_W-1:0]   i_dataIn,

  output logic                o_error
);

  if (OWNER_DEPTH < 2 || (OWNER_DEPTH & (OWNER_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("psx_ddr_arbiter: OWNER_DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
  end

  arb_state_t state;
  mem_req_t   r0_req;
  mem_req_t   r1_req;
  mem_req_t   win_req;
  mem_req_t   cmd_q;
  req_id_t    owner_q;
  req_id_t    grant_id;
  req_id_t    head_id;
  logic       r0_elig;
  logic       r1_elig;
  logic       starve_force;
  logic       grant;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       error_q;

  always_comb begin
    r0_req        = '0;
    r0_req.write  = i_r0_write;
    r0_req.size   = i_r0_commandSize;
    r0_req.adr    = i_r0_adr;
    r0_req.subadr = i_r0_subadr;
    r0_req.mask   = i_r0_writeMask;
    r0_req.data   = i_r0_dataOut;
    r1_req        = '0;
    r1_req.write  = i_r1_write;
    r1_req.size   = i_r1_commandSize;
    r1_req.adr    = i_r1_adr;
    r1_req.subadr = i_r1_subadr;
    r1_req.mask   = i_r1_writeMask;
    r1_req.data   = i_r1_dataOut;
  end

  // reads need a free owner slot; writes never return data
  assign r0_elig = i_r0_command & (i_r0_write | ~fifo_full);
  assign r1_elig = i_r1_command & (i_r1_write | ~fifo_full);

`ifdef PSX_DDR_ARB_STARVE_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign starve_force = r1_elig & (starve_cnt >= STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_id == REQ_GPU) begin
        starve_cnt <= '0;
      end else if (r1_elig && starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  assign grant    = ~i_rst & (state == ST_IDLE) & (r0_elig | r1_elig);
  assign grant_id = (starve_force | ~r0_elig) ? REQ_GPU : REQ_DISPLAY;
  assign win_req  = (grant_id == REQ_GPU) ? r1_req : r0_req;
  assign accept   = (state == ST_ISSUE) & ~i_busy;

  assign o_r0_busy = ~(grant & (grant_id == REQ_DISPLAY));
  assign o_r1_busy = ~(grant & (grant_id == REQ_GPU));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      owner_q <= REQ_DISPLAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            cmd_q   <= win_req;
            owner_q <= grant_id;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_command     = (state == ST_ISSUE);
  assign o_write       = cmd_q.write;
  assign o_commandSize = cmd_q.size;
  assign o_adr         = cmd_q.adr;
  assign o_subadr      = cmd_q.subadr;
  assign o_writeMask   = cmd_q.mask;
  assign o_dataOut     = cmd_q.data;

  assign fifo_push = accept & ~cmd_q.write;
  assign fifo_pop  = i_dataInValid;

  psx_ddr_arb_owner_fifo #(
    .DEPTH (OWNER_DEPTH)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (i_rst),
    .push    (fifo_push),
    .push_id (owner_q),
    .pop     (fifo_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_dataIn         = i_dataIn;
  assign o_r0_dataInValid = ~i_rst & i_dataInValid & ~fifo_empty & (head_id == REQ_DISPLAY);
  assign o_r1_dataInValid = ~i_rst & i_dataInValid & ~fifo_empty & (head_id == REQ_GPU);

  // data with nobody waiting for it means the client and arbiter lost sync
  always_ff @(posedge clk) begin
    if (i_rst) begin
      error_q <= 1'b0;
    end else if (i_dataInValid && fifo_empty) begin
      error_q <= 1'b1;
    end
  end

  assign o_error = error_q;

endmodule

// File: tb/tb_psx_ddr_arbiter.sv
// Self-checking bench for psx_ddr_arbiter: transaction-level model plus directed scenarios.
module tb_psx_ddr_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef PSX_DDR_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         cmd [2];
  logic         wr  [2];
  logic [1:0]   sz  [2];
  logic [14:0]  adr [2];
  logic [2:0]   sub [2];
  logic [15:0]  msk [2];
  logic [255:0] dat [2];
  logic         busy_o [2];
  logic         dv_o   [2];

  logic [255:0] o_dataIn;
  logic         m_command, m_write;
  logic [1:0]   m_size;
  logic [14:0]  m_adr;
  logic [2:0]   m_sub;
  logic [15:0]  m_mask;
  logic [255:0] m_data;
  logic         i_busy = 1'b0;
  logic         i_dataInValid = 1'b0;
  logic [255:0] i_dataIn = '0;
  logic         o_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psx_ddr_arbiter #(.OWNER_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .i_rst(i_rst),
    .i_r0_command(cmd[0]), .i_r0_write(wr[0]), .i_r0_commandSize(sz[0]), .i_r0_adr(adr[0]),
    .i_r0_subadr(sub[0]), .i_r0_writeMask(msk[0]), .i_r0_dataOut(dat[0]),
    .o_r0_busy(busy_o[0]), .o_r0_dataInValid(dv_o[0]),
    .i_r1_command(cmd[1]), .i_r1_write(wr[1]), .i_r1_commandSize(sz[1]), .i_r1_adr(adr[1]),
    .i_r1_subadr(sub[1]), .i_r1_writeMask(msk[1]), .i_r1_dataOut(dat[1]),
    .o_r1_busy(busy_o[1]), .o_r1_dataInValid(dv_o[1]),
    .o_dataIn(o_dataIn),
    .o_command(m_command), .o_write(m_write), .o_commandSize(m_size), .o_adr(m_adr),
    .o_subadr(m_sub), .o_writeMask(m_mask), .o_dataOut(m_data),
    .i_busy(i_busy), .i_dataInValid(i_dataInValid), .i_dataIn(i_dataIn),
    .o_error(o_error)
  );

  function automatic void check(string name, logic [299:0] act, logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit           md_pend;
  int           md_owner;
  logic [292:0] md_fields;
  int           md_q[$];
  bit           md_err;
  int           md_starve;

  always @(negedge clk) begin
    bit e0, e1, force1, gr;
    int win;
    if (i_rst) begin
      check("rst_busy0", busy_o[0], 1'b1);
      check("rst_busy1", busy_o[1], 1'b1);
      check("rst_dv0", dv_o[0], 1'b0);
      check("rst_dv1", dv_o[1], 1'b0);
      md_pend = 0; md_q.delete(); md_err = 0; md_starve = 0;
    end else begin
      e0 = cmd[0] && (wr[0] || md_q.size() < DEPTH);
      e1 = cmd[1] && (wr[1] || md_q.size() < DEPTH);
      force1 = STARVE_ON && e1 && md_starve >= LIMIT;
      gr = !md_pend && (e0 || e1);
      win = (e0 && !force1) ? 0 : 1;
      check("busy0", busy_o[0], !(gr && win == 0));
      check("busy1", busy_o[1], !(gr && win == 1));
      check("command", m_command, md_pend);
      if (md_pend)
        check("fields", {m_write, m_size, m_adr, m_sub, m_mask, m_data}, md_fields);
      check("dv0", dv_o[0], i_dataInValid && md_q.size() > 0 && md_q[0] == 0);
      check("dv1", dv_o[1], i_dataInValid && md_q.size() > 0 && md_q[0] == 1);
      check("dataIn", o_dataIn, i_dataIn);
      check("error", o_error, md_err);
      if (i_dataInValid) begin
        if (md_q.size() > 0) void'(md_q.pop_front());
        else md_err = 1;
      end
      if (md_pend && !i_busy) begin
        if (!md_fields[292]) md_q.push_back(md_owner);
        md_pend = 0;
      end else if (gr) begin
        md_pend   = 1;
        md_owner  = win;
        md_fields = {wr[win], sz[win], adr[win], sub[win], msk[win], dat[win]};
        if (win == 1) md_starve = 0;
        else if (e1 && md_starve < LIMIT) md_starve++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int n, bit c, bit w, logic [1:0] s, logic [14:0] a, logic [2:0] sb,
                         logic [15:0] m);
    cmd[n] = c; wr[n] = w; sz[n] = s; adr[n] = a; sub[n] = sb; msk[n] = m;
    dat[n] = {16{a, 1'b1}};
  endtask

  // raise a request, wait (bounded) for its capture, then drop it; returns in the ISSUE cycle
  task automatic issue(int n, bit w, logic [14:0] a);
    bit got = 0;
    set_req(n, 1'b1, w, 2'd1, a, 3'd2, 16'hF0F0);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!busy_o[n]) begin got = 1; break; end
      tick();
    end
    check("grant_wait", got, 1'b1);
    tick();
    cmd[n] = 1'b0;
  endtask

  initial begin
    int g0, first1;
    for (int n = 0; n < 2; n++) set_req(n, 1'b0, 1'b0, 2'd0, 15'd0, 3'd0, 16'd0);
    repeat (3) tick();
    check("rst_o_command", m_command, 1'b0);
    check("rst_o_adr", m_adr, 15'd0);
    check("rst_o_error", o_error, 1'b0);
    i_rst = 1'b0;
    tick();

    // both read 32 B together: r0 first, r1 two cycles later, returns in order
    set_req(0, 1'b1, 1'b0, 2'd1, 15'h0123, 3'd0, 16'h0000);
    set_req(1, 1'b1, 1'b0, 2'd1, 15'h4567, 3'd3, 16'h0000);
    #1;
    check("both_r0_cap", busy_o[0], 1'b0);
    check("both_r1_wait", busy_o[1], 1'b1);
    tick(); cmd[0] = 1'b0; #1;
    check("both_adr0", m_adr, 15'h0123);
    check("both_r1_issue_busy", busy_o[1], 1'b1);
    tick(); #1;
    check("both_r1_cap", busy_o[1], 1'b0);
    tick(); cmd[1] = 1'b0; #1;
    check("both_adr1", m_adr, 15'h4567);
    tick();
    i_dataInValid = 1'b1; i_dataIn = {8{32'hA5A5_0001}}; #1;
    check("ret_first_r0", dv_o[0], 1'b1);
    check("ret_first_not_r1", dv_o[1], 1'b0);
    check("ret_data", o_dataIn, {8{32'hA5A5_0001}});
    tick();
    i_dataIn = {8{32'h5A5A_0002}}; #1;
    check("ret_second_r1", dv_o[1], 1'b1);
    check("ret_second_not_r0", dv_o[0], 1'b0);
    tick();
    i_dataInValid = 1'b0;

    // memory busy for 5 ISSUE cycles: command held, accepted on the 6th
    i_busy = 1'b1;
    set_req(0, 1'b1, 1'b1, 2'd0, 15'h2AAA, 3'd5, 16'h00FF);
    #1;
    check("hold_cap", busy_o[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); cmd[0] = 1'b0; #1;
      check("hold_command", m_command, 1'b1);
      check("hold_adr", m_adr, 15'h2AAA);
    end
    tick(); i_busy = 1'b0; #1;
    check("hold_accept_cycle", m_command, 1'b1);
    tick(); #1;
    check("hold_done", m_command, 1'b0);

    // owner FIFO full: 5th read stalls, writes still go through
    for (int k = 0; k < 4; k++) issue(1, 1'b0, 15'h0100 + 15'(k));
    set_req(1, 1'b1, 1'b0, 2'd1, 15'h01FF, 3'd1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("full_read_busy", busy_o[1], 1'b1);
    end
    set_req(0, 1'b1, 1'b1, 2'd1, 15'h0777, 3'd0, 16'hFFFF);
    #1;
    check("full_write_cap", busy_o[0], 1'b0);
    tick(); cmd[0] = 1'b0;
    tick();
    i_dataInValid = 1'b1; i_dataIn = {8{32'h0000_0100}}; #1;
    check("full_ret_r1", dv_o[1], 1'b1);
    tick(); i_dataInValid = 1'b0; #1;
    check("full_read_now_cap", busy_o[1], 1'b0);
    tick(); cmd[1] = 1'b0;
    tick();
    i_dataInValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_dataIn = {8{32'h0000_0101 + i}}; #1;
      check("drain_r1", dv_o[1], 1'b1);
      tick();
    end
    i_dataInValid = 1'b0;

    // orphan return: no valid, sticky error until reset
    tick();
    i_dataInValid = 1'b1; i_dataIn = {8{32'hDEAD_BEEF}}; #1;
    check("orphan_dv0", dv_o[0], 1'b0);
    check("orphan_dv1", dv_o[1], 1'b0);
    tick(); i_dataInValid = 1'b0; #1;
    check("orphan_error_set", o_error, 1'b1);
    repeat (3) tick();
    check("orphan_error_sticky", o_error, 1'b1);
    i_rst = 1'b1;
    tick(); i_rst = 1'b0; #1;
    check("orphan_error_cleared", o_error, 1'b0);

    // continuous contention between r0 and r1 writes
    set_req(0, 1'b1, 1'b1, 2'd0, 15'h0010, 3'd0, 16'h000F);
    set_req(1, 1'b1, 1'b1, 2'd0, 15'h0020, 3'd0, 16'h00F0);
    g0 = 0; first1 = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (first1 < 0 && !busy_o[1]) first1 = g0;
      if (first1 < 0 && !busy_o[0]) g0++;
      tick();
    end
`ifdef PSX_DDR_ARB_STARVE_EN
    check("starve_r0_grants_before_r1", first1, 8);
`else
    check("strict_r1_never", first1, -1);
    check("strict_r0_grants", g0, 20);
`endif
    cmd[0] = 1'b0; cmd[1] = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
